// File: rtl/booth_multiplier_seq_if.sv
// Handshake bundle for the sequential Booth multiplier: operand request
// channel (in_valid/in_ready) and product response channel (out_valid/out_ready).
interface booth_multiplier_seq_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;

    modport master (
        output in_valid, multiplicand, multiplier, is_signed, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, is_signed, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-4 Booth multiplier: one recoded digit per CALC cycle, N/2+1 steps,
// signed or unsigned operands. N must be even and >= 4.
module booth_multiplier_seq #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_multiplier_seq_if.slave bus
);
    localparam int ITER = N / 2 + 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam int QW   = N + 2;
    localparam int AW   = N + 3;
    localparam int SW   = AW + QW + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    a_q;
    logic [QW-1:0]    q_q;
    logic [QW-1:0]    m_q;
    logic             q1_q;
    logic [2*N-1:0]   product_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [QW-1:0]    m_ext_d;
    logic [QW-1:0]    q_ext_d;
    logic [AW-1:0]    m_wide;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    a_sum;
    logic [SW-1:0]    shifted;
    logic [AW-1:0]    a_d;
    logic [QW-1:0]    q_d;
    logic             q1_d;
    logic [2*N-1:0]   prod_d;

    // Two extra bits let unsigned operands recode as positive Booth numbers.
    always_comb begin
        m_ext_d = {{2{bus.is_signed & bus.multiplicand[N-1]}}, bus.multiplicand};
        q_ext_d = {{2{bus.is_signed & bus.multiplier[N-1]}}, bus.multiplier};
    end

    always_comb begin
        m_wide = {m_q[QW-1], m_q};
        addend = '0;
        unique case ({q_q[1:0], q1_q})
            3'b001, 3'b010: addend = m_wide;
            3'b011:         addend = m_wide << 1;
            3'b100:         addend = -(m_wide << 1);
            3'b101, 3'b110: addend = -m_wide;
            default:        addend = '0;
        endcase
        a_sum   = a_q + addend;
        shifted = $signed({a_sum, q_q, q1_q}) >>> 2;
        a_d     = shifted[SW-1 -: AW];
        q_d     = shifted[QW:1];
        q1_d    = shifted[0];
        prod_d  = shifted[2*N:1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            q1_q        <= 1'b0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        m_q        <= m_ext_d;
                        q_q        <= q_ext_d;
                        a_q        <= '0;
                        q1_q       <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        product_q   <= prod_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Scoreboard bench: N=8 directed corners plus randomized traffic on N=4/8/16/32,
// expected products from a plain integer multiply.
module tb_booth_multiplier_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] p;
        int          acc;
    } exp_t;

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q,
                                            input int n, input bit s);
        longint am, bm;
        logic [63:0] r;
        am = longint'({32'd0, m});
        bm = longint'({32'd0, q});
        if (s && m[n-1]) am = am - (longint'(1) << n);
        if (s && q[n-1]) bm = bm - (longint'(1) << n);
        r = 64'(am * bm);
        if (n < 32) r = r & ((64'd1 << (2 * n)) - 64'd1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- N=8 instance: directed + random ----------------
    localparam int ITER8 = 5;
    booth_multiplier_seq_if #(.N(8)) b8 ();
    booth_multiplier_seq #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    exp_t q8[$];
    bit   prev_ov8 = 1'b0;
    bit   rnd_or8  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov8 = 1'b0;
        end else if (b8.out_valid) begin
            chk("n8_in_ready_in_done", 64'(b8.in_ready), 64'd0);
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL n8_unexpected_out: product 0x%0h with nothing outstanding", b8.product);
            end else begin
                chk("n8_product", 64'(b8.product), q8[0].p);
                if (!prev_ov8) chk("n8_latency", 64'(cyc - q8[0].acc), 64'(ITER8));
                if (b8.out_ready) void'(q8.pop_front());
            end
            prev_ov8 = !b8.out_ready;
        end else begin
            prev_ov8 = 1'b0;
        end
    end

    task automatic issue8(input logic [7:0] m, input logic [7:0] q, input bit s,
                          input logic [63:0] exp, output int acc);
        int w = 0;
        b8.in_valid     = 1'b1;
        b8.multiplicand = m;
        b8.multiplier   = q;
        b8.is_signed    = s;
        @(negedge clk);
        while (!b8.in_ready && w < 100) begin
            @(posedge clk); #1;
            if (rnd_or8) b8.out_ready = 1'($urandom);
            @(negedge clk);
            w++;
        end
        if (!b8.in_ready) begin
            checks++;
            failures++;
            $display("FAIL n8_accept_timeout: in_ready=0 required 1");
            acc = -1;
        end else begin
            acc = cyc + 1;
            q8.push_back('{exp, acc});
        end
        @(posedge clk); #1;
        b8.in_valid     = 1'b0;
        b8.multiplicand = 8'($urandom);
        b8.multiplier   = 8'($urandom);
        b8.is_signed    = 1'($urandom);
    endtask

    task automatic wait_ov8();
        int w = 0;
        @(negedge clk);
        while (!b8.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!b8.out_valid) begin
            checks++;
            failures++;
            $display("FAIL n8_out_valid_timeout: out_valid=0 required 1");
        end
    endtask

    task automatic drain8();
        int w = 0;
        rnd_or8      = 1'b0;
        b8.out_ready = 1'b1;
        while (q8.size() != 0 && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        if (q8.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL n8_drain_timeout: %0d outstanding required 0", q8.size());
        end
    endtask

    // ---------------- other widths: random traffic ----------------
    for (genvar g = 0; g < 3; g++) begin : g_w
        localparam int W  = (g == 0) ? 4 : (g == 1) ? 16 : 32;
        localparam int IT = W / 2 + 1;
        logic rst;
        bit   done    = 1'b0;
        bit   prev_ov = 1'b0;
        exp_t q[$];
        booth_multiplier_seq_if #(.N(W)) bus ();
        booth_multiplier_seq #(.N(W)) dut (.clk(clk), .rst_n(rst), .bus(bus));

        always @(negedge clk) begin
            if (!rst) begin
                prev_ov = 1'b0;
            end else if (bus.out_valid) begin
                chk($sformatf("n%0d_in_ready_in_done", W), 64'(bus.in_ready), 64'd0);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL n%0d_unexpected_out: product 0x%0h with nothing outstanding", W, bus.product);
                end else begin
                    chk($sformatf("n%0d_product", W), 64'(bus.product), q[0].p);
                    if (!prev_ov) chk($sformatf("n%0d_latency", W), 64'(cyc - q[0].acc), 64'(IT));
                    if (bus.out_ready) void'(q.pop_front());
                end
                prev_ov = !bus.out_ready;
            end else begin
                prev_ov = 1'b0;
            end
        end

        initial begin
            logic [W-1:0] m, qq;
            bit s;
            int w;
            rst = 1'b0;
            bus.in_valid = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
            bus.is_signed = 1'b0; bus.out_ready = 1'b0;
            repeat (3) @(posedge clk); #1;
            rst = 1'b1;
            for (int i = 0; i < 40; i++) begin
                m  = W'($urandom);
                qq = W'($urandom);
                s  = 1'($urandom);
                if (i % 4 == 0) begin m = '0; m[W-1] = 1'b1; end
                if (i % 4 == 1) begin qq = '1; end
                if (i % 8 == 0) begin qq = '0; qq[W-1] = 1'b1; end
                bus.in_valid = 1'b1; bus.multiplicand = m; bus.multiplier = qq; bus.is_signed = s;
                w = 0;
                @(negedge clk);
                while (!bus.in_ready && w < 200) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom);
                    @(negedge clk);
                    w++;
                end
                if (!bus.in_ready) begin
                    checks++;
                    failures++;
                    $display("FAIL n%0d_accept_timeout: in_ready=0 required 1", W);
                end else begin
                    q.push_back('{ref_mul(32'(m), 32'(qq), W, s), cyc + 1});
                end
                @(posedge clk); #1;
                bus.in_valid = 1'($urandom);
                bus.multiplicand = W'($urandom); bus.multiplier = W'($urandom);
                bus.out_ready = 1'($urandom);
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom);
                end
                bus.in_valid = 1'b0;
            end
            bus.out_ready = 1'b1;
            w = 0;
            while (q.size() != 0 && w < 400) begin
                @(posedge clk); #1;
                w++;
            end
            if (q.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL n%0d_drain_timeout: %0d outstanding required 0", W, q.size());
            end
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int a1, a2, w;
        logic [7:0] m, q;
        bit s;

        rst_n = 1'b0;
        b8.in_valid = 1'b1; b8.multiplicand = 8'd3; b8.multiplier = 8'd4;
        b8.is_signed = 1'b0; b8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(b8.in_ready), 64'd1);
        chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
        chk("rst_product", 64'(b8.product), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b8.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_accept", 64'(b8.in_ready), 64'd1);
        @(posedge clk); #1;
        b8.out_ready = 1'b1;

        issue8(8'd7,   8'hFD, 1'b1, 64'hFFEB, a1);
        issue8(8'h80,  8'h80, 1'b1, 64'h4000, a1);
        issue8(8'hFF,  8'hFF, 1'b0, 64'hFE01, a1);
        issue8(8'hFF,  8'hFF, 1'b1, 64'h0001, a1);
        drain8();

        // Backpressure: result must hold for 10 cycles.
        b8.out_ready = 1'b0;
        issue8(8'd5, 8'd6, 1'b0, 64'h001E, a1);
        wait_ov8();
        repeat (10) @(negedge clk);
        chk("bp_out_valid_held", 64'(b8.out_valid), 64'd1);
        chk("bp_in_ready_low", 64'(b8.in_ready), 64'd0);
        chk("bp_product", 64'(b8.product), 64'h001E);
        @(posedge clk); #1;
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 64'(b8.in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(b8.out_valid), 64'd0);

        // Reset lands on the third CALC step and must discard the operation.
        issue8(8'd9, 8'd9, 1'b0, 64'd81, a1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q8.delete();
        chk("midrst_in_ready", 64'(b8.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(b8.out_valid), 64'd0);
        chk("midrst_product", 64'(b8.product), 64'd0);
        for (int i = 0; i < ITER8 + 3; i++) begin
            @(negedge clk);
            chk("midrst_no_out_valid", 64'(b8.out_valid), 64'd0);
        end
        @(posedge clk); #1;
        issue8(8'd3, 8'hFE, 1'b1, 64'hFFFA, a1);
        drain8();

        // Back-to-back with out_ready high: one accept every ITER+2 cycles.
        issue8(8'd11, 8'd13, 1'b0, 64'd143, a1);
        issue8(8'hF0, 8'd2,  1'b1, 64'hFFE0, a2);
        chk("throughput", 64'(a2 - a1), 64'(ITER8 + 2));
        drain8();

        rnd_or8 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m = 8'($urandom);
            q = 8'($urandom);
            s = 1'($urandom);
            issue8(m, q, s, ref_mul(32'(m), 32'(q), 8, s), a1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                b8.out_ready = 1'($urandom);
            end
        end
        drain8();

        w = 0;
        while (!(g_w[0].done && g_w[1].done && g_w[2].done) && w < 20000) begin
            @(posedge clk);
            w++;
        end
        if (!(g_w[0].done && g_w[1].done && g_w[2].done)) begin
            checks++;
            failures++;
            $display("FAIL width_sweep_timeout: sweep incomplete required complete");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
